regdump_tx: RTL and testbench



---
 rtl/regdump_tx_if.sv | 28 ++
 rtl/regdump_tx.sv | 150 +++++++++++++++
 tb/tb_regdump_tx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regdump_tx_if.sv
// Readout bus between the register-dump transmitter and its surroundings:
// start request, register-file read port, serial line and status.
interface regdump_tx_if;
  logic       start;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  rd_data,
    output rd_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/regdump_tx.sv
// Debug readout transmitter: on start, sends a sync byte then registers 0..3
// out a UART TX line (8N1, LSB first), reading them through a dedicated port.
module regdump_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clock,
  input  logic         reset_n,
  regdump_tx_if.master bus
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [CW-1:0] r_baud, w_baud_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [1:0]    r_rd_addr, w_rd_addr_next;
  logic          r_tx, w_tx_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic          w_baud_end;

  assign w_baud_end  = (r_baud == BAUD_LAST);

  assign bus.rd_addr = r_rd_addr;
  assign bus.tx      = r_tx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_bit     <= '0;
      r_baud    <= '0;
      r_shift   <= '0;
      r_rd_addr <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_bit     <= w_bit_next;
      r_baud    <= w_baud_next;
      r_shift   <= w_shift_next;
      r_rd_addr <= w_rd_addr_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  // tx is computed one cycle ahead so the line itself comes straight from a flop.
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_bit_next     = r_bit;
    w_baud_next    = r_baud;
    w_shift_next   = r_shift;
    w_rd_addr_next = r_rd_addr;
    w_tx_next      = r_tx;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (bus.start) begin
          w_state_next   = S_LOAD;
          w_idx_next     = '0;
          w_rd_addr_next = '0;
          w_busy_next    = 1'b1;
          w_baud_next    = '0;
          w_bit_next     = '0;
        end
      end

      S_LOAD: begin
        w_shift_next = (r_idx == 3'd0) ? SYNC_BYTE : bus.rd_data;
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_tx_next    = 1'b0;
        w_state_next = S_START;
      end

      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_tx_next    = r_shift[0];
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_bit_next   = r_bit + 3'd1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end

      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          // The new address is the register for the next byte (byte n reads reg n-1).
          if (r_idx != 3'd4) begin
            w_idx_next     = r_idx + 3'd1;
            w_rd_addr_next = r_idx[1:0];
            w_state_next   = S_LOAD;
          end else begin
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regdump_tx.sv
// Scoreboard bench for regdump_tx: two instances (4 and 2 clocks per bit),
// UART decoding monitors popping expected bytes and read addresses from queues.
module tb_regdump_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  regdump_tx_if busA ();
  regdump_tx_if busB ();

  logic [7:0] regsA [4];
  logic [7:0] regsB [4];

  assign busA.rd_data = regsA[busA.rd_addr];
  assign busB.rd_data = regsB[busB.rd_addr];

  regdump_tx #(.CLKS_PER_BIT(CPB_A), .SYNC_BYTE(8'hA5)) dutA (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busA)
  );

  regdump_tx #(.CLKS_PER_BIT(CPB_B), .SYNC_BYTE(8'hA5)) dutB (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busB)
  );

  logic [1:0] txS, busyS, doneS;
  logic [1:0] addrS [2];
  assign txS      = {busB.tx, busA.tx};
  assign busyS    = {busB.busy, busA.busy};
  assign doneS    = {busB.done, busA.done};
  assign addrS[0] = busA.rd_addr;
  assign addrS[1] = busB.rd_addr;

  logic [7:0] qByteA [$];
  logic [7:0] qByteB [$];
  logic [1:0] qAddrA [$];
  logic [1:0] qAddrB [$];
  int         qGapA  [$];

  int nCompared   = 0;
  int nMismatched = 0;
  int doneCntA    = 0;
  int doneCntB    = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportMissing(input string name, input int act);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing at %0t", name, act, $time);
  endtask

  task automatic pushFrame(input int inst, input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3);
    logic [7:0] bytes [5];
    logic [1:0] addrs [5];
    bytes = '{8'hA5, r0, r1, r2, r3};
    addrs = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      if (inst == 0) begin
        qByteA.push_back(bytes[i]);
        qAddrA.push_back(addrs[i]);
      end else begin
        qByteB.push_back(bytes[i]);
        qAddrB.push_back(addrs[i]);
      end
    end
  endtask

  // UART receiver: detects the start bit, checks rd_addr at the LOAD cycle and
  // the first start-bit cycle, samples each bit mid-period, drops bytes cut by reset.
  task automatic uartMon(input int inst, input int cpb);
    logic [7:0] b;
    logic [1:0] prevAddr;
    logic [1:0] expAddr;
    logic       ok;
    logic       stopBit;
    prevAddr = '0;
    forever begin
      @(negedge clock);
      if (reset_n && txS[inst] == 1'b0) begin
        ok      = 1'b1;
        b       = '0;
        stopBit = 1'b0;
        if ((inst == 0 && qAddrA.size() == 0) || (inst == 1 && qAddrB.size() == 0)) begin
          reportMissing("unexpectedFrameByte", addrS[inst]);
        end else begin
          expAddr = (inst == 0) ? qAddrA.pop_front() : qAddrB.pop_front();
          checkOutput("rdAddrAtLoad", prevAddr, expAddr);
          checkOutput("rdAddrAfterLoad", addrS[inst], expAddr);
        end
        for (int k = 1; k <= 9*cpb + cpb/2; k++) begin
          @(negedge clock);
          if (!reset_n) ok = 1'b0;
          if (k >= cpb + cpb/2 && k < 9*cpb && ((k - cpb/2) % cpb) == 0)
            b[(k - cpb - cpb/2) / cpb] = txS[inst];
          if (k == 9*cpb + cpb/2) stopBit = txS[inst];
        end
        if (ok) begin
          checkOutput("stopBit", stopBit, 1);
          if (inst == 0) begin
            if (qByteA.size() == 0) reportMissing("extraByteA", b);
            else checkOutput("byteA", b, qByteA.pop_front());
          end else begin
            if (qByteB.size() == 0) reportMissing("extraByteB", b);
            else checkOutput("byteB", b, qByteB.pop_front());
          end
        end
      end
      prevAddr = reset_n ? addrS[inst] : 2'd0;
    end
  endtask

  // Busy/done monitor: busy length per frame, done coinciding with busy's fall,
  // and the low gap between back-to-back frames.
  task automatic busyMon(input int inst, input int cpb);
    int   hi;
    int   lo;
    logic prev;
    hi = 0; lo = 0; prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hi = 0; lo = 0; prev = 1'b0;
      end else begin
        if (busyS[inst]) begin
          if (!prev && inst == 0 && qGapA.size() > 0)
            checkOutput("busyLowGap", lo, qGapA.pop_front());
          hi++;
          lo = 0;
        end else begin
          if (prev) begin
            checkOutput("busyLength", hi, 5*(1 + 10*cpb));
            checkOutput("doneAtBusyFall", doneS[inst], 1);
          end else if (doneS[inst]) begin
            reportMissing("strayDone", 1);
          end
          hi = 0;
          lo++;
        end
        if (doneS[inst]) begin
          if (inst == 0) doneCntA++;
          else doneCntB++;
        end
        prev = busyS[inst];
      end
    end
  endtask

  initial uartMon(0, CPB_A);
  initial uartMon(1, CPB_B);
  initial busyMon(0, CPB_A);
  initial busyMon(1, CPB_B);

  // Pulses start for one cycle and checks tx falls exactly one cycle after the sampled edge.
  task automatic applyStimulus(input int inst);
    @(posedge clock);
    #1;
    if (inst == 0) busA.start = 1'b1;
    else busB.start = 1'b1;
    @(posedge clock);
    #1;
    busA.start = 1'b0;
    busB.start = 1'b0;
    @(negedge clock);
    checkOutput("txDuringLoad", txS[inst], 1);
    checkOutput("busyDuringLoad", busyS[inst], 1);
    @(negedge clock);
    checkOutput("txFallLatency", txS[inst], 0);
  endtask

  task automatic waitDone(input int inst, input int target, input int budget);
    int n;
    n = 0;
    while (((inst == 0) ? doneCntA : doneCntB) < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checkOutput("doneCount", (inst == 0) ? doneCntA : doneCntB, target);
  endtask

  initial begin
    int n;
    int seen;
    busA.start = 1'b0;
    busB.start = 1'b0;
    regsA = '{8'h11, 8'h22, 8'h33, 8'h44};
    regsB = '{8'h01, 8'h80, 8'hFF, 8'h3C};

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetTx", busA.tx, 1);
    checkOutput("resetBusy", busA.busy, 0);
    checkOutput("resetDone", busA.done, 0);
    checkOutput("resetRdAddr", busA.rd_addr, 0);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);

    $display("[TB] basic dump");
    pushFrame(0, 8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(0);
    waitDone(0, 1, 400);

    $display("[TB] snapshot");
    pushFrame(0, 8'h11, 8'h22, 8'hFF, 8'h44);
    applyStimulus(0);
    repeat (54) @(posedge clock);
    #1;
    regsA[0] = 8'h99;
    regsA[2] = 8'hFF;
    waitDone(0, 2, 400);

    $display("[TB] start while busy");
    pushFrame(0, 8'h99, 8'h22, 8'hFF, 8'h44);
    applyStimulus(0);
    repeat (60) @(posedge clock);
    #1 busA.start = 1'b1;
    @(posedge clock);
    #1 busA.start = 1'b0;
    waitDone(0, 3, 400);
    repeat (300) @(posedge clock);
    checkOutput("noQueuedFrame", doneCntA, 3);
    checkOutput("noLeftoverBytes", qByteA.size(), 0);

    $display("[TB] start held high");
    pushFrame(0, 8'h99, 8'h22, 8'hFF, 8'h44);
    pushFrame(0, 8'h99, 8'h22, 8'hFF, 8'h44);
    @(posedge clock);
    #1 busA.start = 1'b1;
    n = 0;
    while (!busyS[0] && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("heldBusyRise", busyS[0], 1);
    qGapA.push_back(1);
    n = 0;
    seen = 0;
    while (seen < 2 && n < 1000) begin
      @(negedge clock);
      n++;
      if (doneS[0]) seen++;
    end
    busA.start = 1'b0;
    checkOutput("heldDonePulses", seen, 2);
    repeat (20) @(posedge clock);
    checkOutput("heldDoneCount", doneCntA, 5);
    checkOutput("heldGapChecked", qGapA.size(), 0);
    checkOutput("heldBytesLeft", qByteA.size(), 0);

    $display("[TB] reset mid-frame");
    pushFrame(0, 8'h99, 8'h22, 8'hFF, 8'h44);
    applyStimulus(0);
    repeat (99) @(posedge clock);
    #1;
    checkOutput("busyBeforeReset", busA.busy, 1);
    checkOutput("txBeforeReset", busA.tx, 0);
    checkOutput("rdAddrBeforeReset", busA.rd_addr, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("resetMidTx", busA.tx, 1);
    checkOutput("resetMidBusy", busA.busy, 0);
    checkOutput("resetMidRdAddr", busA.rd_addr, 0);
    checkOutput("resetMidDone", busA.done, 0);
    repeat (3) @(posedge clock);
    qByteA.delete();
    qAddrA.delete();
    #2 reset_n = 1'b1;
    repeat (50) @(posedge clock);
    checkOutput("noDoneAfterReset", doneCntA, 5);
    pushFrame(0, 8'h99, 8'h22, 8'hFF, 8'h44);
    applyStimulus(0);
    waitDone(0, 6, 400);

    $display("[TB] minimum divider");
    pushFrame(1, 8'h01, 8'h80, 8'hFF, 8'h3C);
    applyStimulus(1);
    waitDone(1, 1, 200);
    repeat (10) @(posedge clock);
    checkOutput("minDivBytesLeft", qByteB.size(), 0);
    checkOutput("finalDoneCountA", doneCntA, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
